// File: rtl/validator_lane_scheduler.sv
// Round-robin dispatch of transactions to parallel validator lanes,
// with in-order re-emission of passing results and drop counting.
module validator_lane_scheduler #(
  parameter int NUM_LANES  = 4,
  parameter int DROP_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [127:0]              data_i,
  input  logic                      valid_i,
  output logic                      ack_o,
  output logic [NUM_LANES-1:0]      lane_start_o,
  output logic [127:0]              lane_data_o,
  input  logic [NUM_LANES-1:0]      lane_done_i,
  input  logic [NUM_LANES-1:0]      lane_pass_i,
  input  logic [NUM_LANES*128-1:0]  lane_result_i,
  output logic [127:0]              data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [DROP_CNT_W-1:0]     drop_cnt_o,
  output logic                      stray_done_o
);

  localparam int IDW = $clog2(NUM_LANES);
  localparam int CW  = IDW + 1;

  typedef enum logic {
    IDLE,
    PRESENT
  } col_state_e;

  logic [NUM_LANES-1:0]  busy_q, busy_d;
  logic [NUM_LANES-1:0]  have_q, have_d;
  logic [NUM_LANES-1:0]  pass_q, pass_d;
  logic [127:0]          res_q [NUM_LANES];
  logic [127:0]          res_in [NUM_LANES];
  logic [IDW-1:0]        ord_q [NUM_LANES];
  logic [IDW-1:0]        hd_q, hd_d, tl_q, tl_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IDW-1:0]        rr_q, rr_d;
  logic [NUM_LANES-1:0]  start_q, start_d;
  logic [127:0]          ldata_q, ldata_d;
  logic [127:0]          dout_q, dout_d;
  col_state_e            st_q, st_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  stray_q, stray_d;

  logic [IDW-1:0]        gnt, idx, h;
  logic                  gnt_vld, accept;
  logic [NUM_LANES-1:0]  cap;
  logic                  h_have, h_pass;
  logic [127:0]          h_res;
  logic                  pop, load, drop;

  always_comb begin
    for (int n = 0; n < NUM_LANES; n++) begin
      res_in[n] = lane_result_i[128*n +: 128];
    end
  end

  // First free lane at or after rr_q, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = rr_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = rr_q + IDW'(i);
      if (!gnt_vld && !busy_q[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  assign accept = rst & valid_i & gnt_vld;
  assign ack_o  = accept;

  assign cap     = lane_done_i & busy_q & ~have_q;
  assign stray_d = stray_q | (|(lane_done_i & ~(busy_q & ~have_q)));

  // A verdict arriving this cycle for the head lane is used directly.
  assign h      = ord_q[hd_q];
  assign h_have = have_q[h] | cap[h];
  assign h_pass = have_q[h] ? pass_q[h] : lane_pass_i[h];
  assign h_res  = have_q[h] ? res_q[h] : res_in[h];

  always_comb begin
    st_d   = st_q;
    pop    = 1'b0;
    load   = 1'b0;
    drop   = 1'b0;
    dout_d = dout_q;
    unique case (st_q)
      IDLE: begin
        if (cnt_q != '0 && h_have) begin
          if (h_pass) begin
            load   = 1'b1;
            dout_d = h_res;
            st_d   = PRESENT;
          end else begin
            pop  = 1'b1;
            drop = 1'b1;
          end
        end
      end
      PRESENT: begin
        if (ready_i) begin
          pop  = 1'b1;
          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d  = busy_q;
    have_d  = have_q | cap;
    pass_d  = pass_q;
    start_d = '0;
    ldata_d = ldata_q;
    rr_d    = rr_q;
    drop_d  = drop_q;
    for (int n = 0; n < NUM_LANES; n++) begin
      if (cap[n]) pass_d[n] = lane_pass_i[n];
    end
    if (accept) begin
      busy_d[gnt]  = 1'b1;
      start_d[gnt] = 1'b1;
      ldata_d      = data_i;
      rr_d         = gnt + IDW'(1);
    end
    if (pop) begin
      busy_d[h] = 1'b0;
      have_d[h] = 1'b0;
    end
    if (drop && drop_q != '1) drop_d = drop_q + DROP_CNT_W'(1);
    tl_d  = tl_q + IDW'(accept);
    hd_d  = hd_q + IDW'(pop);
    cnt_d = cnt_q + CW'(accept) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= '0;
      have_q  <= '0;
      pass_q  <= '0;
      hd_q    <= '0;
      tl_q    <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
      start_q <= '0;
      ldata_q <= '0;
      dout_q  <= '0;
      st_q    <= IDLE;
      drop_q  <= '0;
      stray_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      have_q  <= have_d;
      pass_q  <= pass_d;
      hd_q    <= hd_d;
      tl_q    <= tl_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      start_q <= start_d;
      ldata_q <= ldata_d;
      dout_q  <= dout_d;
      st_q    <= st_d;
      drop_q  <= drop_d;
      stray_q <= stray_d;
    end
  end

  // Payload storage is qualified by busy/have/queue count.
  always_ff @(posedge clk) begin
    if (accept) ord_q[tl_q] <= gnt;
    for (int n = 0; n < NUM_LANES; n++) begin
      if (cap[n]) res_q[n] <= res_in[n];
    end
  end

  assign lane_start_o = start_q;
  assign lane_data_o  = ldata_q;
  assign data_o       = dout_q;
  assign valid_o      = (st_q == PRESENT);
  assign drop_cnt_o   = drop_q;
  assign stray_done_o = stray_q;

endmodule

// File: tb/tb_validator_lane_scheduler.sv
// Directed bench for validator_lane_scheduler: ordering, rejects,
// backpressure, round-robin wrap, stray done and reset.
module tb_validator_lane_scheduler;

  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [127:0]  data_i = '0;
  logic          valid_i = 1'b0;
  logic          ack_o;
  logic [NL-1:0] lane_start_o;
  logic [127:0]  lane_data_o;
  logic [NL-1:0] lane_done_i = '0;
  logic [NL-1:0] lane_pass_i = '0;
  logic [NL*128-1:0] lane_result_i = '0;
  logic [127:0]  data_o;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic [15:0]   drop_cnt_o;
  logic          stray_done_o;

  logic          s_ack, s_valid, s_stray;
  logic [NL-1:0] s_start;
  logic [127:0]  s_ldata, s_data;
  logic [1:0]    s_drop;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] got[$];

  always #5 clk = ~clk;

  validator_lane_scheduler dut (
    .clk(clk), .rst(rst),
    .data_i(data_i), .valid_i(valid_i), .ack_o(ack_o),
    .lane_start_o(lane_start_o), .lane_data_o(lane_data_o),
    .lane_done_i(lane_done_i), .lane_pass_i(lane_pass_i),
    .lane_result_i(lane_result_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .drop_cnt_o(drop_cnt_o), .stray_done_o(stray_done_o)
  );

  validator_lane_scheduler #(.NUM_LANES(4), .DROP_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .data_i(data_i), .valid_i(valid_i), .ack_o(s_ack),
    .lane_start_o(s_start), .lane_data_o(s_ldata),
    .lane_done_i(lane_done_i), .lane_pass_i(lane_pass_i),
    .lane_result_i(lane_result_i),
    .data_o(s_data), .valid_o(s_valid), .ready_i(ready_i),
    .drop_cnt_o(s_drop), .stray_done_o(s_stray)
  );

  always @(negedge clk) begin
    if (rst && valid_o && ready_i) got.push_back(data_o);
  end

  function automatic logic [127:0] X(input int k);
    return {96'h5A5A0000_FFFF0000_12345678, 32'(k)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    lane_done_i = '0;
    repeat (2) tick();
    rst = 1'b1;
    got.delete();
  endtask

  task automatic push(input logic [127:0] x, input int lane);
    logic [NL-1:0] oh;
    oh = NL'(1) << lane;
    valid_i = 1'b1;
    data_i = x;
    #1;
    chk("push_ack", 128'(ack_o), 128'd1);
    tick();
    valid_i = 1'b0;
    chk("push_start", 128'(lane_start_o), 128'(oh));
    chk("push_ldata", lane_data_o, x);
  endtask

  task automatic done_p(input int lane, input logic pass,
                        input logic [127:0] res);
    lane_done_i[lane] = 1'b1;
    lane_pass_i[lane] = pass;
    lane_result_i[128*lane +: 128] = res;
    tick();
    lane_done_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state with a pending upstream transaction
    valid_i = 1'b1;
    data_i = X(77);
    #12;
    chk("rst_ack", 128'(ack_o), 128'd0);
    chk("rst_start", 128'(lane_start_o), 128'd0);
    chk("rst_ldata", lane_data_o, 128'd0);
    chk("rst_valid", 128'(valid_o), 128'd0);
    chk("rst_data", data_o, 128'd0);
    chk("rst_drop", 128'(drop_cnt_o), 128'd0);
    chk("rst_stray", 128'(stray_done_o), 128'd0);

    // Single transaction
    do_reset();
    push(128'h0123456789ABCDEF_00000000000000A5, 0);
    repeat (3) tick();
    chk("s1_pre_valid", 128'(valid_o), 128'd0);
    done_p(0, 1'b1, 128'h0123456789ABCDEF_00000000000000A5);
    chk("s1_valid", 128'(valid_o), 128'd1);
    chk("s1_data", data_o, 128'h0123456789ABCDEF_00000000000000A5);
    tick();
    chk("s1_popped", 128'(valid_o), 128'd0);

    // Out-of-order completion, in-order emission
    do_reset();
    for (int k = 0; k < 4; k++) push(X(k), k);
    valid_i = 1'b1;
    data_i = X(4);
    #1;
    chk("s2_full_ack", 128'(ack_o), 128'd0);
    done_p(3, 1'b1, X(3));
    chk("s2_hold_valid", 128'(valid_o), 128'd0);
    chk("s2_full_ack2", 128'(ack_o), 128'd0);
    done_p(1, 1'b1, X(1));
    done_p(0, 1'b1, X(0));
    chk("s2_x0_valid", 128'(valid_o), 128'd1);
    chk("s2_x0_data", data_o, X(0));
    chk("s2_ack_busy", 128'(ack_o), 128'd0);
    tick();
    chk("s2_ack_freed", 128'(ack_o), 128'd1);
    tick();
    valid_i = 1'b0;
    chk("s2_x4_start", 128'(lane_start_o), 128'd1);
    chk("s2_x4_ldata", lane_data_o, X(4));
    done_p(2, 1'b1, X(2));
    repeat (2) tick();
    done_p(0, 1'b1, X(4));
    repeat (8) tick();
    chk("s2_n", 128'(got.size()), 128'd5);
    if (got.size() == 5) begin
      for (int k = 0; k < 5; k++) chk("s2_out", got[k], X(k));
    end

    // Rejects, saturation and round-robin wrap 3 -> 0
    do_reset();
    for (int k = 0; k < 3; k++) push(X(k), k);
    done_p(0, 1'b1, X(0));
    done_p(1, 1'b0, X(1));
    done_p(2, 1'b1, X(2));
    repeat (6) tick();
    chk("s3_drop1", 128'(drop_cnt_o), 128'd1);
    chk("s3_n", 128'(got.size()), 128'd2);
    if (got.size() == 2) begin
      chk("s3_out0", got[0], X(0));
      chk("s3_out1", got[1], X(2));
    end
    push(X(3), 3);
    push(X(4), 0);
    push(X(5), 1);
    push(X(6), 2);
    done_p(3, 1'b0, X(3));
    done_p(0, 1'b0, X(4));
    repeat (4) tick();
    chk("s3_drop3", 128'(drop_cnt_o), 128'd3);
    chk("s3_sat3", 128'(s_drop), 128'd3);
    done_p(1, 1'b0, X(5));
    done_p(2, 1'b0, X(6));
    repeat (4) tick();
    chk("s3_drop5", 128'(drop_cnt_o), 128'd5);
    chk("s3_sat_hold", 128'(s_drop), 128'd3);
    chk("s3_n_end", 128'(got.size()), 128'd2);

    // Backpressure
    do_reset();
    ready_i = 1'b0;
    for (int k = 0; k < 4; k++) push(X(10 + k), k);
    for (int k = 0; k < 4; k++) done_p(k, 1'b1, X(10 + k));
    valid_i = 1'b1;
    data_i = X(14);
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("s4_valid", 128'(valid_o), 128'd1);
      chk("s4_data", data_o, X(10));
      chk("s4_ack", 128'(ack_o), 128'd0);
      tick();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (10) tick();
    chk("s4_n", 128'(got.size()), 128'd4);
    if (got.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("s4_out", got[k], X(10 + k));
    end

    // Stray done, reset mid-flight
    do_reset();
    chk("s6_stray0", 128'(stray_done_o), 128'd0);
    done_p(2, 1'b1, X(9));
    chk("s6_stray1", 128'(stray_done_o), 128'd1);
    repeat (3) tick();
    chk("s6_sticky", 128'(stray_done_o), 128'd1);
    ready_i = 1'b0;
    push(X(20), 0);
    push(X(21), 1);
    done_p(0, 1'b1, X(20));
    chk("s6_pre_valid", 128'(valid_o), 128'd1);
    valid_i = 1'b1;
    data_i = X(22);
    rst = 1'b0;
    #1;
    chk("s6_rst_ack", 128'(ack_o), 128'd0);
    chk("s6_rst_start", 128'(lane_start_o), 128'd0);
    chk("s6_rst_ldata", lane_data_o, 128'd0);
    chk("s6_rst_valid", 128'(valid_o), 128'd0);
    chk("s6_rst_data", data_o, 128'd0);
    chk("s6_rst_stray", 128'(stray_done_o), 128'd0);
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    rst = 1'b1;
    done_p(1, 1'b1, X(21));
    chk("s6_post_stray", 128'(stray_done_o), 128'd1);
    chk("s6_post_valid", 128'(valid_o), 128'd0);
    push(X(23), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
